// File: rtl/long_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : long_op_scheduler
// Purpose : Sequences the multi-cycle MUL/DIV unit, owns the shared RF port
//           during its write slot and raises the ID-stage scoreboard hazard.
// Rev     : 1.0
// ============================================================================
module long_op_scheduler #(
  parameter int MUL_LATENCY  = 4,
  parameter int DIV_LATENCY  = 33,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        issue_valid_i,
  input  logic [2:0]  issue_funct3_i,
  input  logic [4:0]  issue_rd_i,
  output logic        unit_start_o,
  input  logic [31:0] unit_result_i,
  input  logic        pipe_wb_en_i,
  input  logic [4:0]  pipe_wb_rd_i,
  input  logic [31:0] pipe_wb_data_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic [4:0]  id_rd_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_wdata_o,
  output logic        busy_o,
  output logic        hazard_o,
  output logic        wb_stall_o,
  output logic        long_done_o
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_START = 2'd1;
  localparam logic [1:0] c_RUN   = 2'd2;
  localparam logic [1:0] c_PEND  = 2'd3;

  localparam int c_MAXLAT = (DIV_LATENCY > MUL_LATENCY) ? DIV_LATENCY : MUL_LATENCY;
  localparam int c_CW     = $clog2(c_MAXLAT + 1);
  localparam int c_SW     = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  localparam logic [c_CW-1:0] c_MUL_LOAD   = c_CW'(MUL_LATENCY - 1);
  localparam logic [c_CW-1:0] c_DIV_LOAD   = c_CW'(DIV_LATENCY - 1);
  localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_LIMIT);

  logic [1:0]      r_state;
  logic [1:0]      w_next_state;
  logic [c_CW-1:0] r_count;
  logic            r_is_div;
  logic [4:0]      r_rd;
  logic [31:0]     r_hold;
  logic [c_SW-1:0] r_starve;
  logic            w_long_win;
  logic            w_busy;
  logic            w_unused;

  // Only funct3[2] distinguishes MUL from DIV/REM latency.
  assign w_unused = ^issue_funct3_i[1:0];

  assign w_busy     = (r_state != c_IDLE);
  assign w_long_win = (r_state == c_PEND) &&
                      (!pipe_wb_en_i || (r_starve == c_STARVE_MAX));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (issue_valid_i) w_next_state = c_START;
      c_START: w_next_state = c_RUN;
      c_RUN:   if (r_count == '0) w_next_state = c_PEND;
      c_PEND:  if (w_long_win) w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count  <= '0;
      r_is_div <= 1'b0;
      r_rd     <= '0;
      r_hold   <= '0;
      r_starve <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (issue_valid_i) begin
            r_rd     <= issue_rd_i;
            r_is_div <= issue_funct3_i[2];
          end
        end
        c_START: r_count <= r_is_div ? c_DIV_LOAD : c_MUL_LOAD;
        c_RUN: begin
          if (r_count == '0) begin
            r_hold <= unit_result_i;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        c_PEND: begin
          // Losing a PEND cycle to MEM/WB is the only way to stay in PEND.
          if (w_long_win) begin
            r_starve <= '0;
          end else begin
            r_starve <= r_starve + 1'b1;
          end
        end
        default: r_starve <= '0;
      endcase
    end
  end

  always_comb begin
    unit_start_o = (r_state == c_START);
    busy_o       = w_busy;
    hazard_o     = w_busy && (r_rd != 5'd0) &&
                   ((r_rd == id_rs1_i) || (r_rd == id_rs2_i) || (r_rd == id_rd_i));
    rf_we_o      = pipe_wb_en_i;
    rf_rd_o      = pipe_wb_rd_i;
    rf_wdata_o   = pipe_wb_data_i;
    wb_stall_o   = 1'b0;
    long_done_o  = 1'b0;
    if (w_long_win) begin
      rf_we_o     = (r_rd != 5'd0);
      rf_rd_o     = r_rd;
      rf_wdata_o  = r_hold;
      wb_stall_o  = pipe_wb_en_i;
      long_done_o = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_long_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_long_op_scheduler
// Purpose : Directed self-checking bench with a write-result scoreboard.
// Rev     : 1.0
// ============================================================================
module tb_long_op_scheduler;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 33;
  localparam int STARVE  = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        issue_valid_i;
  logic [2:0]  issue_funct3_i;
  logic [4:0]  issue_rd_i;
  logic        unit_start_o;
  logic [31:0] unit_result_i;
  logic        pipe_wb_en_i;
  logic [4:0]  pipe_wb_rd_i;
  logic [31:0] pipe_wb_data_i;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic [4:0]  id_rd_i;
  logic        rf_we_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_wdata_o;
  logic        busy_o;
  logic        hazard_o;
  logic        wb_stall_o;
  logic        long_done_o;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk_i = ~clk_i;

  long_op_scheduler #(
    .MUL_LATENCY (MUL_LAT),
    .DIV_LATENCY (DIV_LAT),
    .STARVE_LIMIT(STARVE)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .issue_valid_i (issue_valid_i),
    .issue_funct3_i(issue_funct3_i),
    .issue_rd_i    (issue_rd_i),
    .unit_start_o  (unit_start_o),
    .unit_result_i (unit_result_i),
    .pipe_wb_en_i  (pipe_wb_en_i),
    .pipe_wb_rd_i  (pipe_wb_rd_i),
    .pipe_wb_data_i(pipe_wb_data_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rd_i       (id_rd_i),
    .rf_we_o       (rf_we_o),
    .rf_rd_o       (rf_rd_o),
    .rf_wdata_o    (rf_wdata_o),
    .busy_o        (busy_o),
    .hazard_o      (hazard_o),
    .wb_stall_o    (wb_stall_o),
    .long_done_o   (long_done_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One long op from issue to the cycle after its write; n_pipe PEND cycles go to MEM/WB first.
  task automatic do_op(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] res,
                       input int n_pipe, input logic [4:0] hz, input int hz_port, input bit spur);
    int   lat;
    logic exp_hz;
    exp_t e;
    lat    = f3[2] ? DIV_LAT : MUL_LAT;
    exp_hz = (rd != 5'd0) && (hz == rd);
    id_rs1_i = (hz_port == 0) ? hz : 5'd31;
    id_rs2_i = (hz_port == 1) ? hz : 5'd31;
    id_rd_i  = (hz_port == 2) ? hz : 5'd31;
    issue_valid_i  = 1'b1;
    issue_funct3_i = f3;
    issue_rd_i     = rd;
    pipe_wb_en_i   = 1'b0;
    unit_result_i  = ~res;
    e.rd = rd; e.data = res; e.we = (rd != 5'd0);
    q.push_back(e);
    @(negedge clk_i);
    chk("issue_busy", busy_o, 0);
    chk("issue_hazard", hazard_o, 0);
    chk("issue_start", unit_start_o, 0);
    tick();
    issue_valid_i = 1'b0;
    issue_rd_i    = 5'd0;
    @(negedge clk_i);
    chk("start_pulse", unit_start_o, 1);
    chk("start_busy", busy_o, 1);
    chk("start_hazard", hazard_o, exp_hz);
    for (int k = 2; k <= lat + 1; k++) begin
      tick();
      unit_result_i = (k == lat + 1) ? res : ~res;
      if (spur && k == 3) begin
        issue_valid_i = 1'b1; issue_rd_i = 5'd3; issue_funct3_i = 3'd0;
      end else begin
        issue_valid_i = 1'b0;
      end
      @(negedge clk_i);
      chk("run_start", unit_start_o, 0);
      chk("run_busy", busy_o, 1);
      chk("run_hazard", hazard_o, exp_hz);
      chk("run_we", rf_we_o, 0);
      chk("run_done", long_done_o, 0);
    end
    for (int p = 0; p < n_pipe; p++) begin
      tick();
      unit_result_i  = ~res;
      issue_valid_i  = 1'b0;
      pipe_wb_en_i   = 1'b1;
      pipe_wb_rd_i   = 5'd20 + 5'(p);
      pipe_wb_data_i = 32'h1000 + p;
      @(negedge clk_i);
      chk("pend_pipe_we", rf_we_o, 1);
      chk("pend_pipe_rd", rf_rd_o, 32'd20 + p);
      chk("pend_pipe_data", rf_wdata_o, 32'h1000 + p);
      chk("pend_pipe_stall", wb_stall_o, 0);
      chk("pend_pipe_done", long_done_o, 0);
      chk("pend_pipe_hazard", hazard_o, exp_hz);
    end
    tick();
    unit_result_i  = ~res;
    pipe_wb_en_i   = (n_pipe == STARVE);
    pipe_wb_rd_i   = 5'd25;
    pipe_wb_data_i = 32'h5555;
    issue_valid_i  = spur;
    issue_rd_i     = 5'd3;
    @(negedge clk_i);
    chk("write_done", long_done_o, 1);
    chk("write_stall", wb_stall_o, (n_pipe == STARVE));
    chk("write_busy", busy_o, 1);
    chk("write_hazard", hazard_o, exp_hz);
    chk("sb_size", q.size(), 1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("write_we", rf_we_o, e.we);
      chk("write_rd", rf_rd_o, e.rd);
      chk("write_data", rf_wdata_o, e.data);
    end
    tick();
    issue_valid_i = 1'b0;
    pipe_wb_en_i  = 1'b0;
    @(negedge clk_i);
    chk("after_busy", busy_o, 0);
    chk("after_done", long_done_o, 0);
    chk("after_hazard", hazard_o, 0);
    chk("after_start", unit_start_o, 0);
    chk("after_stall", wb_stall_o, 0);
    chk("after_we", rf_we_o, 0);
    tick();
  endtask

  initial begin
    rst_i = 1'b1; issue_valid_i = 1'b0; issue_funct3_i = 3'd0; issue_rd_i = 5'd0;
    unit_result_i = 32'h0; pipe_wb_en_i = 1'b0; pipe_wb_rd_i = 5'd0; pipe_wb_data_i = 32'h0;
    id_rs1_i = 5'd0; id_rs2_i = 5'd0; id_rd_i = 5'd0;
    repeat (3) tick();
    @(negedge clk_i);
    chk("rst_busy", busy_o, 0);
    chk("rst_start", unit_start_o, 0);
    chk("rst_hazard", hazard_o, 0);
    chk("rst_we", rf_we_o, 0);
    chk("rst_done", long_done_o, 0);
    chk("rst_stall", wb_stall_o, 0);
    tick();
    rst_i = 1'b0;
    pipe_wb_en_i = 1'b1; pipe_wb_rd_i = 5'd4; pipe_wb_data_i = 32'h1234;
    @(negedge clk_i);
    chk("idle_pass_we", rf_we_o, 1);
    chk("idle_pass_rd", rf_rd_o, 4);
    chk("idle_pass_data", rf_wdata_o, 32'h1234);
    chk("idle_pass_stall", wb_stall_o, 0);
    tick();
    pipe_wb_en_i = 1'b0;
    repeat (4) tick();

    do_op(5'd5, 3'b000, 32'hCAFE_0005, 0, 5'd5, 0, 1'b0);   // MUL x5
    do_op(5'd7, 3'b100, 32'h0000_0707, 0, 5'd7, 0, 1'b0);   // DIV x7, rs1 hazard
    do_op(5'd9, 3'b000, 32'h0000_00AA, STARVE, 5'd9, 1, 1'b0); // starvation, rs2 hazard
    do_op(5'd0, 3'b001, 32'h0BAD_0000, 0, 5'd0, 0, 1'b0);   // rd=x0
    do_op(5'd14, 3'b110, 32'h1414_1414, 2, 5'd14, 2, 1'b1); // REM, ignored issues, rd hazard
    do_op(5'd11, 3'b011, 32'h2222_1111, 1, 5'd12, 0, 1'b0); // no dependency

    // Abandon a DIV mid-RUN with reset.
    id_rs1_i = 5'd12; id_rs2_i = 5'd31; id_rd_i = 5'd31;
    issue_valid_i = 1'b1; issue_funct3_i = 3'b101; issue_rd_i = 5'd12;
    unit_result_i = 32'hDEAD_BEEF;
    tick();
    issue_valid_i = 1'b0;
    repeat (13) tick();
    @(negedge clk_i);
    chk("abort_busy", busy_o, 1);
    chk("abort_hazard", hazard_o, 1);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("abort_rst_busy", busy_o, 0);
    chk("abort_rst_hazard", hazard_o, 0);
    chk("abort_rst_start", unit_start_o, 0);
    chk("abort_rst_we", rf_we_o, 0);
    chk("abort_rst_done", long_done_o, 0);
    chk("abort_rst_stall", wb_stall_o, 0);
    tick();
    do_op(5'd12, 3'b000, 32'h0C0C_0C0C, 0, 5'd12, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/long_op_scheduler.md
Name: long_op_scheduler

Overview:
Controls the multi-cycle M-extension unit (MUL/DIV/REM) behind the EX stage. Accepts a long-op issue and pulses the start strobe to the mul/div datapath. Counts its fixed latency, captures the result and schedules it onto the single register-file write port, which it shares with normal MEM/WB writeback. Also drives a scoreboard hazard to the ID stage for instructions that depend on the pending destination register.

Parameters:
MUL_LATENCY, 4, cycles from unit_start_o to a valid unit_result_i for funct3[2]=0
DIV_LATENCY, 33, same for funct3[2]=1 (DIV/DIVU/REM/REMU)
STARVE_LIMIT, 3, PEND cycles the long result may lose arbitration before it forces priority

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
issue_valid_i  in  1  EX holds a long op (is_long, not flushed, no busywait)
issue_funct3_i  in  3  M-ext funct3 of issued op
issue_rd_i  in  5  destination register of issued op
unit_start_o  out  1  one-cycle start pulse to mul/div datapath
unit_result_i  in  32  mul/div result; valid on the cycle the latency count expires
pipe_wb_en_i  in  1  MEM/WB write request
pipe_wb_rd_i  in  5  MEM/WB destination
pipe_wb_data_i  in  32  MEM/WB data
id_rs1_i  in  5  ID-stage rs1 label
id_rs2_i  in  5  ID-stage rs2 label
id_rd_i  in  5  ID-stage rd label
rf_we_o  out  1  register-file write enable
rf_rd_o  out  5  register-file write address
rf_wdata_o  out  32  register-file write data
busy_o  out  1  state != IDLE; EX must not issue another long op
hazard_o  out  1  ID must stall (scoreboard match)
wb_stall_o  out  1  MEM/WB must freeze and re-present its write next cycle
long_done_o  out  1  one-cycle pulse when the long result is written

Behaviour:
- Reset (synchronous, rst_i high at a clock edge): state=IDLE, counter=0, pending rd=0, holding reg=0, starve count=0. All outputs are 0. An in-flight op is abandoned and its result is dropped.
- States: IDLE, START, RUN, PEND.
- IDLE: if issue_valid_i=1, latch rd, select latency by funct3[2], go to START. Otherwise stay.
- Issue is accepted only in IDLE. issue_valid_i in any other state is ignored; upstream must honour busy_o.
- START (1 cycle): unit_start_o=1, counter=LAT-1, go to RUN.
- RUN: decrement the counter each cycle. On the cycle the counter=0, capture unit_result_i into the holding reg and go to PEND.
- PEND, write-port arbitration:
  - pipe_wb_en_i=0: the long result wins. rf_we_o=(pending rd!=0), rf_rd_o=pending rd, rf_wdata_o=holding reg, long_done_o=1, go to IDLE.
  - pipe_wb_en_i=1 and starve count<STARVE_LIMIT: the pipeline wins, the port passes MEM/WB through, and the starve count increments.
  - pipe_wb_en_i=1 and starve count=STARVE_LIMIT: the long result wins, wb_stall_o=1, write as above, go to IDLE.
  - The starve count clears on leaving PEND.
- Outside a PEND long win, the rf_* outputs are a combinational passthrough of the pipe_wb_* inputs.
- Timing, MUL: issue sampled at edge T, unit_start_o in cycle T+1, capture in cycle T+1+LAT, earliest write in cycle T+2+LAT.
- Timing, DIV: capture in T+34, earliest write in T+35.
- hazard_o=1 when state!=IDLE, pending rd!=0, and pending rd equals id_rs1_i, id_rs2_i or id_rd_i. The id_rd_i match prevents WAW.
- hazard_o is combinational and deasserts in the cycle after the long write.
- rd=x0: the op runs the full sequence with rf_we_o=0 during the long slot. long_done_o still pulses, and hazard_o is never raised.
- Same-cycle events:
  - PEND long write followed by a new issue: the issue in that same cycle is ignored because busy_o is still 1. The next issue is accepted in IDLE.
  - rst_i has priority over every event.

Test Plan:
- MUL x5 issued at cycle 10, pipe_wb_en_i=0 -> unit_start_o at 11, capture at 15, rf_we_o=1/rf_rd_o=5/rf_wdata_o=result at 16, long_done_o at 16, busy_o 0 from 17.
- DIV x7 at cycle 0 with id_rs1_i=7 -> hazard_o=1 from cycle 1 until the write in cycle 35; busy_o=1 cycles 1-35.
- PEND with pipe_wb_en_i held 1 (rd=9, data=0xAA) and STARVE_LIMIT=3 -> three cycles of pipeline writes, then wb_stall_o=1 and the long write in the 4th PEND cycle.
- MUL with rd=0 -> no rf_we_o in the long slot, long_done_o pulses, hazard_o stays 0 for id_rs1_i=0.
- rst_i asserted mid-RUN (DIV, count=20) -> next cycle IDLE with all outputs 0, no write ever occurs, and a new issue is accepted in the following cycle.
- issue_valid_i pulsed during RUN with rd=3 -> ignored; only the original rd is written and no second unit_start_o occurs.
